mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch requester and data load/store requester. It sits between the multicycle control unit's fetch/memory phases and a synchronous SRAM with configurable read latency. It serializes accesses with round-robin arbitration and allows one outstanding access at a time. Each requester gets a grant pulse and a completion pulse carrying read data.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch and data load/store requesters. Round-robin arbitration,
// one outstanding access, grant pulse at issue and completion pulse with data.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W/8-1:0]   d_we,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic                sel_data;
  logic                last_data;
  logic                take;
  logic                take_data;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     we_q;
  logic [DATA_W-1:0]   wdata_q;

  // state register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state and requester selection (take = latch a new requester)
  always_comb begin
    state_next = state;
    take       = 1'b0;
    take_data  = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          take       = 1'b1;
          // on contention the requester not granted last wins
          take_data  = d_req && (!if_req || !last_data);
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // only the other requester may be chained straight into ISSUE
        if (sel_data ? if_req : d_req) begin
          take       = 1'b1;
          take_data  = !sel_data;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // request latch, round-robin pointer, wait counter and read-data capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_data  <= 1'b0;
      last_data <= 1'b1;
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (take) begin
        sel_data <= take_data;
        addr_q   <= take_data ? d_addr : if_addr;
        we_q     <= take_data ? d_we : '0;
        wdata_q  <= take_data ? d_wdata : '0;
      end
      case (state)
        ISSUE: begin
          last_data <= sel_data;
          cnt       <= LAT4;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (sel_data) begin
              d_rdata <= (we_q != '0) ? '0 : mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decoded purely from state and registered request fields
  always_comb begin
    if_gnt    = (state == ISSUE) && !sel_data;
    d_gnt     = (state == ISSUE) && sel_data;
    if_rvalid = (state == RESP) && !sel_data;
    d_rvalid  = (state == RESP) && sel_data;
    busy      = (state != IDLE);
    mem_en    = (state == ISSUE);
    mem_addr  = (state == ISSUE) ? addr_q : '0;
    mem_we    = (state == ISSUE) ? we_q : '0;
    mem_wdata = (state == ISSUE) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiter instances (MEM_LAT = 2, 1, 15) share the
// same requester inputs; each has its own memory model that only presents
// valid read data in the exact cycle MEM_LAT after mem_en.
module tb_mem_port_arbiter;

  localparam logic [31:0] MAGIC = 32'h00500193;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;

  logic        if_gnt_a[3];
  logic        if_rvalid_a[3];
  logic [31:0] if_rdata_a[3];
  logic        d_gnt_a[3];
  logic        d_rvalid_a[3];
  logic [31:0] d_rdata_a[3];
  logic        mem_en_a[3];
  logic [31:0] mem_addr_a[3];
  logic [3:0]  mem_we_a[3];
  logic [31:0] mem_wdata_a[3];
  logic        busy_a[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    logic [3:0]  mcnt = '0;
    logic [31:0] laddr = '0;
    logic [31:0] rd;

    // memory model: data valid only in the cycle LAT after the issue cycle
    always @(posedge clk) begin
      if (mem_en_a[k]) begin
        mcnt  <= 4'(LAT);
        laddr <= mem_addr_a[k];
      end else if (mcnt != 4'd0) begin
        mcnt <= mcnt - 4'd1;
      end
    end

    assign rd = (mcnt == 4'd1) ? (laddr ^ MAGIC) : 32'hBADBAD00;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt_a[k]),
      .if_rvalid (if_rvalid_a[k]),
      .if_rdata  (if_rdata_a[k]),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_we      (d_we),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_a[k]),
      .d_rvalid  (d_rvalid_a[k]),
      .d_rdata   (d_rdata_a[k]),
      .mem_en    (mem_en_a[k]),
      .mem_addr  (mem_addr_a[k]),
      .mem_we    (mem_we_a[k]),
      .mem_wdata (mem_wdata_a[k]),
      .mem_rdata (rd),
      .busy      (busy_a[k])
    );
  end

  // fetch-only latency monitor: records grant/completion cycles per instance
  int cyc = 0;
  bit mon_en = 1'b0;
  int gcyc[3][4];
  int rcyc[3][4];
  int n_g[3];
  int n_r[3];
  int men_n[3];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!mon_en) begin
        n_g[k] = 0;
        n_r[k] = 0;
        men_n[k] = 0;
        for (int i = 0; i < 4; i++) begin
          gcyc[k][i] = -100;
          rcyc[k][i] = -1000;
        end
      end else begin
        if (if_gnt_a[k]) begin
          if (n_g[k] < 4) gcyc[k][n_g[k]] = cyc;
          n_g[k]++;
        end
        if (if_rvalid_a[k]) begin
          if (n_r[k] < 4) rcyc[k][n_r[k]] = cyc;
          n_r[k]++;
        end
        if (mem_en_a[k]) men_n[k]++;
      end
    end
  end

  typedef struct {
    bit           ifr;
    bit           dr;
    logic [31:0]  ia;
    logic [31:0]  da;
    logic [159:0] exp;
  } vec_t;

  vec_t tbl[23];

  // flags order: {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, busy}
  function automatic vec_t mk(bit ifr, bit dr, logic [31:0] ia, logic [31:0] da,
                              logic [5:0] flags, logic [31:0] maddr,
                              logic [31:0] ird, logic [31:0] drd);
    vec_t v;
    v.ifr = ifr;
    v.dr  = dr;
    v.ia  = ia;
    v.da  = da;
    v.exp = {22'b0, flags, maddr, 4'b0, 32'b0, ird, drd};
    return v;
  endfunction

  function automatic logic [159:0] outs(int k);
    return {22'b0, if_gnt_a[k], if_rvalid_a[k], d_gnt_a[k], d_rvalid_a[k],
            mem_en_a[k], busy_a[k], mem_addr_a[k], mem_we_a[k],
            mem_wdata_a[k], if_rdata_a[k], d_rdata_a[k]};
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] got,
                             input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit ifr, input bit dr, input logic [31:0] ia,
                               input logic [31:0] da, input logic [3:0] we,
                               input logic [31:0] wd);
    if_req  = ifr;
    d_req   = dr;
    if_addr = ia;
    d_addr  = da;
    d_we    = we;
    d_wdata = wd;
  endtask

  task automatic applyReset();
    rstn = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // directed test sequence
  initial begin
    logic [31:0] a_v, b_v, c_v, d_v, e_v;
    int men_cnt;
    int rv_cnt;
    int who[10];
    int at[10];
    int ng;
    int prev;
    int viol;
    bit prev_men;

    a_v = 32'h00500093;
    b_v = 32'h00500097;
    c_v = 32'h0050009B;
    d_v = 32'h00503193;
    e_v = 32'h00503197;

    tbl[0]  = mk(1, 1, 32'h100, 32'h3000, 6'b000000, 32'h0,    32'h0, 32'h0);
    tbl[1]  = mk(1, 1, 32'h100, 32'h3000, 6'b100011, 32'h100,  32'h0, 32'h0);
    tbl[2]  = mk(1, 1, 32'h100, 32'h3000, 6'b000001, 32'h0,    32'h0, 32'h0);
    tbl[3]  = mk(1, 1, 32'h100, 32'h3000, 6'b000001, 32'h0,    32'h0, 32'h0);
    tbl[4]  = mk(1, 1, 32'h100, 32'h3000, 6'b010001, 32'h0,    a_v,   32'h0);
    tbl[5]  = mk(1, 1, 32'h104, 32'h3000, 6'b001011, 32'h3000, a_v,   32'h0);
    tbl[6]  = mk(1, 1, 32'h104, 32'h3000, 6'b000001, 32'h0,    a_v,   32'h0);
    tbl[7]  = mk(1, 1, 32'h104, 32'h3000, 6'b000001, 32'h0,    a_v,   32'h0);
    tbl[8]  = mk(1, 1, 32'h104, 32'h3000, 6'b000101, 32'h0,    a_v,   d_v);
    tbl[9]  = mk(1, 0, 32'h104, 32'h3000, 6'b100011, 32'h104,  a_v,   d_v);
    tbl[10] = mk(1, 0, 32'h104, 32'h3000, 6'b000001, 32'h0,    a_v,   d_v);
    tbl[11] = mk(1, 0, 32'h104, 32'h3000, 6'b000001, 32'h0,    a_v,   d_v);
    tbl[12] = mk(1, 0, 32'h104, 32'h3000, 6'b010001, 32'h0,    b_v,   d_v);
    tbl[13] = mk(1, 1, 32'h108, 32'h3004, 6'b000000, 32'h0,    b_v,   d_v);
    tbl[14] = mk(1, 1, 32'h108, 32'h3004, 6'b001011, 32'h3004, b_v,   d_v);
    tbl[15] = mk(1, 1, 32'h108, 32'h3004, 6'b000001, 32'h0,    b_v,   d_v);
    tbl[16] = mk(1, 1, 32'h108, 32'h3004, 6'b000001, 32'h0,    b_v,   d_v);
    tbl[17] = mk(1, 1, 32'h108, 32'h3004, 6'b000101, 32'h0,    b_v,   e_v);
    tbl[18] = mk(1, 0, 32'h108, 32'h3004, 6'b100011, 32'h108,  b_v,   e_v);
    tbl[19] = mk(1, 0, 32'h108, 32'h3004, 6'b000001, 32'h0,    b_v,   e_v);
    tbl[20] = mk(1, 0, 32'h108, 32'h3004, 6'b000001, 32'h0,    b_v,   e_v);
    tbl[21] = mk(1, 0, 32'h108, 32'h3004, 6'b010001, 32'h0,    c_v,   e_v);
    tbl[22] = mk(0, 0, 32'h108, 32'h3004, 6'b000000, 32'h0,    c_v,   e_v);

    applyReset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_state[%0d]", k), outs(k), 160'h0);
    end

    // contention from reset, chained RESP->ISSUE and pointer flip
    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1 applyStimulus(tbl[i].ifr, tbl[i].dr, tbl[i].ia, tbl[i].da, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("vec[%0d]", i), outs(0), tbl[i].exp);
    end

    // partial store
    @(posedge clk);
    #1 applyStimulus(0, 1, 32'h108, 32'h2000, 4'b0011, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    checkOutput("store_issue",
                {86'b0, d_gnt_a[0], if_gnt_a[0], mem_en_a[0], mem_addr_a[0],
                 mem_we_a[0], mem_wdata_a[0]},
                {86'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 4'b0011, 32'hDEADBEEF});
    men_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      men_cnt += int'(mem_en_a[0]);
    end
    @(negedge clk);
    checkOutput("store_resp", {95'b0, d_rvalid_a[0], d_rdata_a[0], if_rdata_a[0]},
                {95'b0, 1'b1, 32'h0, c_v});
    @(posedge clk);
    #1 applyStimulus(0, 0, 32'h108, 32'h2000, 4'h0, 32'h0);
    @(negedge clk);
    men_cnt += int'(mem_en_a[0]);
    checkOutput("store_after", {128'b0, 31'(men_cnt), busy_a[0]}, 160'h0);

    // asynchronous reset in the middle of a fetch WAIT
    @(posedge clk);
    #1 applyStimulus(1, 0, 32'h200, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    applyStimulus(0, 0, 32'h200, 32'h0, 4'h0, 32'h0);
    #1 checkOutput("reset_in_wait", outs(0), 160'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rv_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      rv_cnt += int'(if_rvalid_a[0]) + int'(d_rvalid_a[0]);
    end
    checkOutput("no_rvalid_after_reset", 160'(rv_cnt), 160'h0);
    @(posedge clk);
    #1 applyStimulus(1, 0, 32'h204, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("fresh_issue", {126'b0, if_gnt_a[0], mem_en_a[0], mem_addr_a[0]},
                {126'b0, 1'b1, 1'b1, 32'h204});
    repeat (3) @(negedge clk);
    checkOutput("fresh_resp", {127'b0, if_rvalid_a[0], if_rdata_a[0]},
                {127'b0, 1'b1, 32'h00500397});
    @(posedge clk);
    #1 applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 32'h0);

    // single requester re-requesting on all three latencies
    applyReset();
    @(posedge clk);
    #1 applyStimulus(1, 0, 32'h400, 32'h0, 4'h0, 32'h0);
    mon_en = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("lat%0d_gnt_to_rvalid[%0d]", lat_of(k), i),
                    160'(rcyc[k][i] - gcyc[k][i]), 160'(lat_of(k) + 1));
      end
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("lat%0d_period[%0d]", lat_of(k), i),
                    160'(gcyc[k][i+1] - gcyc[k][i]), 160'(lat_of(k) + 3));
      end
      checkOutput($sformatf("lat%0d_mem_en_per_grant", lat_of(k)),
                  {96'b0, 32'(men_n[k]), 32'(n_g[k])},
                  {96'b0, 32'(n_g[k]), 32'(n_g[k] > 2 ? n_g[k] : 3)});
    end
    mon_en = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 32'h0);

    // both requesters held: strict alternation starting with fetch
    applyReset();
    @(posedge clk);
    #1 applyStimulus(1, 1, 32'h300, 32'h3100, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      who[i] = -1;
      at[i]  = -1000;
    end
    ng = 0;
    viol = 0;
    prev_men = 1'b0;
    for (int t = 0; t < 48; t++) begin
      @(negedge clk);
      if (ng < 10 && (if_gnt_a[0] || d_gnt_a[0])) begin
        who[ng] = d_gnt_a[0] ? 1 : 0;
        at[ng]  = t;
        ng++;
      end
      if ((mem_en_a[0] && prev_men) || (if_gnt_a[0] && d_gnt_a[0]) ||
          (if_rvalid_a[0] && d_rvalid_a[0]) || (if_gnt_a[0] && if_rvalid_a[0]) ||
          (d_gnt_a[0] && d_rvalid_a[0])) begin
        viol++;
      end
      prev_men = mem_en_a[0];
    end
    prev = -3;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("alternate[%0d]", i),
                  {96'b0, 32'(who[i]), 32'(at[i] - prev)},
                  {96'b0, 32'(i % 2), 32'd4});
      prev = at[i];
    end
    checkOutput("exclusivity", 160'(viol), 160'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
